mesh_sort_ctrl: RTL and testbench

Central sequencer for the Nanci sort-routed mesh. It drives the shared control lines that every PE in the SQRT_N×SQRT_N mesh samples each cycle: packet load, compare-exchange enable, odd/even parity, and row/column axis. It runs a full shearsort (snake-order row phases interleaved with column phases) from a single `start` request and pulses `done` when packets have reached their destination PEs. It sits beside the `mesh` instance at the top level and replaces free-running per-PE sort counters.

---
 rtl/mesh_pkg.sv | 29 ++
 rtl/mesh_step_counter.sv | 40 ++++
 rtl/mesh_sort_ctrl.sv | 121 ++++++++++++
 tb/tb_mesh_sort_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared types and sizing helpers for the mesh sort sequencer
package mesh_pkg;

    // Sequencer states: one load cycle, then SORT phases separated by GAP bubbles
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_GAP,
        ST_DONE
    } sort_state_t;

    // Phase axis as seen by every PE: rows are walked in snake order
    typedef enum logic {
        AXIS_ROW = 1'b0,
        AXIS_COL = 1'b1
    } axis_t;

    // Shearsort alternates row and column phases and ends on a row phase
    function automatic int num_phases(input int log_sqrt_n);
        return 2 * log_sqrt_n + 1;
    endfunction

    // Bits needed to index 0..range_n-1, never fewer than one
    function automatic int cnt_width(input int range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/mesh_step_counter.sv
// rtl/mesh_step_counter.sv - compare-exchange step counter with clear, stall hold and terminal flag
import mesh_pkg::*;

module mesh_step_counter #(
    parameter int COUNT = 4,
    parameter int W     = cnt_width(COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         stall,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         tc
);

    // Terminal count marks the last step of a phase; the counter parks there
    assign tc = (cnt == W'(COUNT - 1));

    // Next count: clear wins, stall freezes, otherwise advance up to the terminal value
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (en && !stall && !tc) begin
            cnt_next = cnt + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/mesh_sort_ctrl.sv
// rtl/mesh_sort_ctrl.sv - central shearsort sequencer driving the shared mesh control lines
import mesh_pkg::*;

module mesh_sort_ctrl #(
    parameter int  N           = 4,
    parameter int  SQRT_N      = 2,
    parameter int  LOG_SQRT_N  = 1,
    parameter int  SORT_CYCLES = 4,
    localparam int NUM_PHASES  = num_phases(LOG_SQRT_N),
    localparam int PHASE_W     = cnt_width(NUM_PHASES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               ready,
    output logic               load_en,
    output logic               step_en,
    output logic               step_odd,
    output logic               axis,
    output logic [PHASE_W-1:0] phase_idx,
    output logic               done
);

    localparam int CNT_W = cnt_width(SORT_CYCLES);

    // A mesh whose side or log side disagrees with N cannot be sequenced correctly
    if (SQRT_N * SQRT_N != N || (1 << LOG_SQRT_N) != SQRT_N) begin : g_bad_geometry
        $error("mesh_sort_ctrl: inconsistent mesh geometry");
    end

    sort_state_t        state;
    sort_state_t        state_next;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_next;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   step_cnt_next;
    logic               step_tc;
    logic               last_phase;
    logic               step_go;
    logic               unused_cnt;

    assign last_phase = (phase_q == PHASE_W'(NUM_PHASES - 1));

    // Only the parity of the upcoming step leaves the counter
    assign unused_cnt = ^{step_cnt, step_cnt_next};

    mesh_step_counter #(
        .COUNT (SORT_CYCLES),
        .W     (CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_SORT),
        .en       (state == ST_SORT),
        .stall    (stall),
        .cnt      (step_cnt),
        .cnt_next (step_cnt_next),
        .tc       (step_tc)
    );

    // Next state and phase number; stall only matters while sorting and beats phase completion
    always_comb begin
        state_next = state;
        phase_next = phase_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    phase_next = '0;
                end
            end
            ST_LOAD: begin
                state_next = ST_SORT;
            end
            ST_SORT: begin
                if (!stall && step_tc) begin
                    state_next = last_phase ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = ST_SORT;
                phase_next = phase_q + PHASE_W'(1);
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A step happens in the coming cycle unless a sorting cycle is being frozen
    assign step_go = (state_next == ST_SORT) && !((state == ST_SORT) && stall);

    // State, phase and control outputs, all registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase_q  <= '0;
            ready    <= 1'b1;
            load_en  <= 1'b0;
            step_en  <= 1'b0;
            step_odd <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            phase_q  <= phase_next;
            ready    <= (state_next == ST_IDLE);
            load_en  <= (state_next == ST_LOAD);
            step_en  <= step_go;
            step_odd <= step_go && step_cnt_next[0];
            done     <= (state_next == ST_DONE);
        end
    end

    assign phase_idx = phase_q;
    assign axis      = phase_q[0] ? AXIS_COL : AXIS_ROW;

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// tb/tb_mesh_sort_ctrl.sv - randomized self-checking bench for mesh_sort_ctrl at two mesh sizes
module tb_mesh_sort_ctrl;

    localparam int SC = 4;
    localparam int K_LOAD = 0;
    localparam int K_STEP = 1;
    localparam int K_GAP  = 2;
    localparam int K_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;

    logic       ready4, load4, step4, odd4, axis4, done4;
    logic [1:0] ph4;
    logic       ready16, load16, step16, odd16, axis16, done16;
    logic [2:0] ph16;

    mesh_sort_ctrl #(.N(4), .SQRT_N(2), .LOG_SQRT_N(1), .SORT_CYCLES(SC)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .ready(ready4), .load_en(load4), .step_en(step4), .step_odd(odd4),
        .axis(axis4), .phase_idx(ph4), .done(done4)
    );

    mesh_sort_ctrl #(.N(16), .SQRT_N(4), .LOG_SQRT_N(2), .SORT_CYCLES(SC)) dut16 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .ready(ready16), .load_en(load16), .step_en(step16), .step_odd(odd16),
        .axis(axis16), .phase_idx(ph16), .done(done16)
    );

    // Observed outputs packed as {ready, load_en, step_en, step_odd, axis, done, phase_idx[3:0]}
    logic [9:0] obs [2];
    assign obs[0] = {ready4, load4, step4, odd4, axis4, done4, 2'b00, ph4};
    assign obs[1] = {ready16, load16, step16, odd16, axis16, done16, 1'b0, ph16};

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: a run is a fixed list of slots (LOAD, steps, GAPs, DONE);
    // a stall inserts frozen cycles between slots while sorting
    int nph [2] = '{3, 5};
    bit busy [2];
    int slot [2];
    bit frozen [2];
    int phase_hold [2];

    function automatic void decode(input int np, input int k, output int kind, output int ph, output int st);
        int j;
        st = 0;
        if (k == 0) begin
            kind = K_LOAD; ph = 0;
        end else if (k == np * (SC + 1)) begin
            kind = K_DONE; ph = np - 1;
        end else begin
            j = k - 1;
            ph = j / (SC + 1);
            st = j % (SC + 1);
            kind = (st == SC) ? K_GAP : K_STEP;
        end
    endfunction

    function automatic void model_edge(input int i, input bit r, input bit s, input bit st);
        int kind, ph, stp;
        if (r) begin
            busy[i] = 0; frozen[i] = 0; phase_hold[i] = 0;
        end else if (!busy[i]) begin
            if (s) begin
                busy[i] = 1; slot[i] = 0; frozen[i] = 0;
            end
        end else begin
            decode(nph[i], slot[i], kind, ph, stp);
            if (st && (frozen[i] || kind == K_STEP)) begin
                frozen[i] = 1;
            end else begin
                frozen[i] = 0;
                slot[i] = slot[i] + 1;
                if (slot[i] > nph[i] * (SC + 1)) busy[i] = 0;
            end
        end
        if (busy[i]) begin
            decode(nph[i], slot[i], kind, ph, stp);
            phase_hold[i] = ph;
        end
    endfunction

    function automatic logic [9:0] expect_vec(input int i);
        int kind, ph, st;
        logic rd, ld, se, so, dn;
        rd = 0; ld = 0; se = 0; so = 0; dn = 0;
        ph = phase_hold[i];
        if (!busy[i]) begin
            rd = 1;
        end else if (!frozen[i]) begin
            decode(nph[i], slot[i], kind, ph, st);
            if (kind == K_LOAD) ld = 1;
            if (kind == K_STEP) begin se = 1; so = 1'(st % 2); end
            if (kind == K_DONE) dn = 1;
        end
        return {rd, ld, se, so, 1'(ph % 2), dn, 4'(ph)};
    endfunction

    task automatic cycle(input bit r, input bit s, input bit st);
        rst = r; start = s; stall = st;
        @(posedge clk);
        model_edge(0, r, s, st);
        model_edge(1, r, s, st);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        for (int n = 0; n < 3; n++) begin
            cycle(1, n == 1, n == 2);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expect_vec(i)) begin
                    errors++;
                    $display("FAIL reset inst%0d cyc%0d got=%b want=%b", i, cyc, obs[i], expect_vec(i));
                end
            end
        end
        checks++;
        if ({ready4, load4, step4, odd4, axis4, done4, ph4} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_values got=%b want=10000000", {ready4, load4, step4, odd4, axis4, done4, ph4});
        end
    endtask

    // Runs one sort with a given stall window (cycles relative to the start edge) and checks latency
    task automatic run_one(input string name, input int stall_lo, input int stall_hi,
                           input int want4, input int want16, input int want_steps4);
        int t, d4, d16, steps4;
        d4 = -1; d16 = -1; steps4 = 0;
        for (int n = 0; n < 4; n++) cycle(0, 0, 0);
        t = cyc;
        cycle(0, 1, 0);
        for (int n = 0; n < 100 && (busy[0] || busy[1]); n++) begin
            cycle(0, 0, (cyc - t) >= stall_lo && (cyc - t) <= stall_hi);
            if (done4 === 1'b1 && d4 < 0) d4 = cyc - t;
            if (done16 === 1'b1 && d16 < 0) d16 = cyc - t;
            if (step4 === 1'b1) steps4++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expect_vec(i)) begin
                    errors++;
                    $display("FAIL %s inst%0d cyc%0d got=%b want=%b", name, i, cyc, obs[i], expect_vec(i));
                end
            end
        end
        checks++;
        if (d4 !== want4) begin
            errors++;
            $display("FAIL %s done4_latency got=%0d want=%0d", name, d4, want4);
        end
        checks++;
        if (d16 !== want16) begin
            errors++;
            $display("FAIL %s done16_latency got=%0d want=%0d", name, d16, want16);
        end
        checks++;
        if (steps4 !== want_steps4) begin
            errors++;
            $display("FAIL %s step4_count got=%0d want=%0d", name, steps4, want_steps4);
        end
    endtask

    task automatic test_basic;
        run_one("basic", -1, -1, 16, 26, 12);
    endtask

    // Stall sampled at the edges ending phase-1 step 1 and the two following cycles
    task automatic test_stall;
        run_one("stall", 8, 10, 19, 29, 12);
    endtask

    task automatic test_start_while_busy;
        int loads4, dones4;
        bit hit_done;
        loads4 = 0; dones4 = 0; hit_done = 0;
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        if (load4 === 1'b1) loads4++;
        for (int n = 0; n < 100 && (busy[0] || busy[1]); n++) begin
            // pulse start during a SORT cycle and again during the DONE cycle of the small mesh
            cycle(0, n == 3 || (expect_vec(0) & 10'h010) != 0, 0);
            if (load4 === 1'b1) loads4++;
            if (done4 === 1'b1) begin dones4++; hit_done = 1; end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expect_vec(i)) begin
                    errors++;
                    $display("FAIL busy_start inst%0d cyc%0d got=%b want=%b", i, cyc, obs[i], expect_vec(i));
                end
            end
        end
        checks++;
        if (loads4 !== 1 || dones4 !== 1) begin
            errors++;
            $display("FAIL busy_start pulses got loads=%0d dones=%0d want loads=1 dones=1", loads4, dones4);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        cycle(0, 1, 0);
        for (int n = 0; n < 8; n++) begin
            cycle(0, 0, 0);
            if (done4 === 1'b1 || done16 === 1'b1) dones++;
        end
        cycle(1, 0, 0);
        checks++;
        if ({ready4, load4, step4, odd4, axis4, done4, ph4} !== 8'b1000_0000 ||
            {ready16, load16, step16, odd16, axis16, done16, ph16} !== 9'b1000_00000) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b/%b want=10000000/100000000",
                     {ready4, load4, step4, odd4, axis4, done4, ph4},
                     {ready16, load16, step16, odd16, axis16, done16, ph16});
        end
        for (int n = 0; n < 30; n++) begin
            cycle(0, 0, 0);
            if (done4 === 1'b1 || done16 === 1'b1) dones++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expect_vec(i)) begin
                    errors++;
                    $display("FAIL reset_mid inst%0d cyc%0d got=%b want=%b", i, cyc, obs[i], expect_vec(i));
                end
            end
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid aborted_done got=%0d want=0", dones);
        end
        run_one("after_reset", -1, -1, 16, 26, 12);
    endtask

    task automatic test_random;
        bit r, s, st;
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom % 97) == 0;
            s  = ($urandom % 4) == 0;
            st = ($urandom % 3) == 0;
            cycle(r, s, st);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expect_vec(i)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got=%b want=%b", i, cyc, obs[i], expect_vec(i));
                end
            end
        end
        cycle(1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
